// File: rtl/eth_io_cmd_arbiter_pkg.sv
// rtl/eth_io_cmd_arbiter_pkg.sv - shared Ethernet IO types: config, requester IDs, engine command enums
package eth_io_cmd_arbiter_pkg;

    typedef enum int {
        e_bp_default_cfg = 0,
        e_bp_small_cfg   = 1
    } bp_params_e;

    typedef enum logic [0:0] {
        e_eth_io_req_rx = 1'b0,
        e_eth_io_req_tx = 1'b1
    } eth_io_req_e;

    typedef enum logic [1:0] {
        e_eth_rx_cmd_wr_data = 2'd0,
        e_eth_rx_cmd_wr_len  = 2'd1,
        e_eth_rx_cmd_irq     = 2'd2
    } eth_rx_cmd_e;

    typedef enum logic [1:0] {
        e_eth_tx_cmd_rd_data = 2'd0,
        e_eth_tx_cmd_rd_len  = 2'd1,
        e_eth_tx_cmd_done    = 2'd2
    } eth_tx_cmd_e;

    function automatic int cce_mem_msg_width(input bp_params_e cfg);
        return (cfg == e_bp_default_cfg) ? 128 : 64;
    endfunction

endpackage

// File: rtl/eth_io_cmd_arbiter_tag_fifo.sv
// rtl/eth_io_cmd_arbiter_tag_fifo.sv - 1-bit order-preserving tag FIFO, no bypass
module eth_io_tag_fifo #(
    parameter int els_p = 8,
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int cnt_w_lp = $clog2(els_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                data_i,
    input  logic                push_i,
    input  logic                pop_i,
    output logic                data_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [cnt_w_lp-1:0] count_o
);

    logic [els_p-1:0]    mem;
    logic [ptr_w_lp-1:0] rd_ptr, wr_ptr;
    logic [cnt_w_lp-1:0] count;

    // Pointers wrap at els_p, which need not be a power of two
    function automatic logic [ptr_w_lp-1:0] bump(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (push_i) mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_i) wr_ptr <= bump(wr_ptr);
            if (pop_i)  rd_ptr <= bump(rd_ptr);
            case ({push_i, pop_i})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign data_o  = mem[rd_ptr];
    assign full_o  = (count == cnt_w_lp'(els_p));
    assign empty_o = (count == '0);
    assign count_o = count;

endmodule

// File: rtl/eth_io_cmd_arbiter.sv
// rtl/eth_io_cmd_arbiter.sv - round-robin RX/TX share of the IO command channel with tagged response return
module eth_io_cmd_arbiter
    import eth_io_cmd_arbiter_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    parameter int els_p = 8,
    localparam int cce_mem_msg_width_lp = cce_mem_msg_width(bp_params_p),
    localparam int cnt_w_lp = $clog2(els_p + 1)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [cce_mem_msg_width_lp-1:0] rx_cmd_i,
    input  logic                            rx_cmd_v_i,
    output logic                            rx_cmd_yumi_o,
    input  logic [cce_mem_msg_width_lp-1:0] tx_cmd_i,
    input  logic                            tx_cmd_v_i,
    output logic                            tx_cmd_yumi_o,
    output logic [cce_mem_msg_width_lp-1:0] rx_resp_o,
    output logic                            rx_resp_v_o,
    input  logic                            rx_resp_ready_i,
    output logic [cce_mem_msg_width_lp-1:0] tx_resp_o,
    output logic                            tx_resp_v_o,
    input  logic                            tx_resp_ready_i,
    output logic [cce_mem_msg_width_lp-1:0] io_cmd_o,
    output logic                            io_cmd_v_o,
    input  logic                            io_cmd_yumi_i,
    input  logic [cce_mem_msg_width_lp-1:0] io_resp_i,
    input  logic                            io_resp_v_i,
    output logic                            io_resp_ready_o,
    output logic [cnt_w_lp-1:0]             outstanding_o
);

    eth_io_req_e last_grant_r, grant;
    logic        full, empty, head_tx, push, pop;
    logic        rx_elig, tx_elig;

    assign rx_elig = rx_cmd_v_i & ~full & ~reset_i;
    assign tx_elig = tx_cmd_v_i & ~full & ~reset_i;

    always_comb begin
        grant = e_eth_io_req_rx;
        if (rx_elig && tx_elig)
            grant = (last_grant_r == e_eth_io_req_tx) ? e_eth_io_req_rx : e_eth_io_req_tx;
        else if (tx_elig)
            grant = e_eth_io_req_tx;
    end

    assign io_cmd_v_o    = rx_elig | tx_elig;
    assign io_cmd_o      = (grant == e_eth_io_req_tx) ? tx_cmd_i : rx_cmd_i;
    assign push          = io_cmd_v_o & io_cmd_yumi_i;
    assign rx_cmd_yumi_o = push & (grant == e_eth_io_req_rx);
    assign tx_cmd_yumi_o = push & (grant == e_eth_io_req_tx);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)   last_grant_r <= e_eth_io_req_tx;
        else if (push) last_grant_r <= grant;
    end

    // The FIFO head names the requester owed the oldest outstanding response
    assign io_resp_ready_o = ~reset_i & ~empty & (head_tx ? tx_resp_ready_i : rx_resp_ready_i);
    assign rx_resp_v_o     = ~reset_i & io_resp_v_i & ~empty & ~head_tx;
    assign tx_resp_v_o     = ~reset_i & io_resp_v_i & ~empty &  head_tx;
    assign rx_resp_o       = io_resp_i;
    assign tx_resp_o       = io_resp_i;
    assign pop             = io_resp_v_i & io_resp_ready_o;

    eth_io_tag_fifo #(.els_p(els_p)) tag_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (grant == e_eth_io_req_tx),
        .push_i  (push),
        .pop_i   (pop),
        .data_o  (head_tx),
        .full_o  (full),
        .empty_o (empty),
        .count_o (outstanding_o)
    );

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        io_cmd_yumi_i |-> io_cmd_v_o);
    a_resp_needs_tag: assert property (@(posedge clk_i) disable iff (reset_i)
        io_resp_v_i |-> !empty);

endmodule

// File: tb/tb_eth_io_cmd_arbiter.sv
// tb/tb_eth_io_cmd_arbiter.sv - vector table, corner sequences and randomized model check of eth_io_cmd_arbiter
module tb_eth_io_cmd_arbiter;
    import eth_io_cmd_arbiter_pkg::*;

    localparam int W   = cce_mem_msg_width(e_bp_default_cfg);
    localparam int ELS = 8;
    localparam int CW  = $clog2(ELS + 1);

    logic         clk = 1'b0, reset_i = 1'b1;
    logic [W-1:0] rx_cmd_i = '0, tx_cmd_i = '0, io_resp_i = '0;
    logic         rx_cmd_v_i = 0, tx_cmd_v_i = 0, io_cmd_yumi_i = 0, io_resp_v_i = 0;
    logic         rx_resp_ready_i = 0, tx_resp_ready_i = 0;
    logic [W-1:0] rx_resp_o, tx_resp_o, io_cmd_o;
    logic         rx_cmd_yumi_o, tx_cmd_yumi_o, rx_resp_v_o, tx_resp_v_o, io_cmd_v_o, io_resp_ready_o;
    logic [CW-1:0] outstanding_o;

    eth_io_cmd_arbiter #(.bp_params_p(e_bp_default_cfg), .els_p(ELS)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .rx_cmd_i(rx_cmd_i), .rx_cmd_v_i(rx_cmd_v_i), .rx_cmd_yumi_o(rx_cmd_yumi_o),
        .tx_cmd_i(tx_cmd_i), .tx_cmd_v_i(tx_cmd_v_i), .tx_cmd_yumi_o(tx_cmd_yumi_o),
        .rx_resp_o(rx_resp_o), .rx_resp_v_o(rx_resp_v_o), .rx_resp_ready_i(rx_resp_ready_i),
        .tx_resp_o(tx_resp_o), .tx_resp_v_o(tx_resp_v_o), .tx_resp_ready_i(tx_resp_ready_i),
        .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_yumi_i(io_cmd_yumi_i),
        .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_ready_o(io_resp_ready_o),
        .outstanding_o(outstanding_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    task automatic chki(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_msg();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference model: queue of requester IDs in issue order plus last winner
    int q[$];
    int last_g = 1;
    bit m_cmd_v, m_push, m_pop, m_rdy, m_rx_rv, m_tx_rv;
    int m_g;

    task automatic step(input bit rxv, input bit txv, input bit yreq,
                        input bit rspv, input bit rxr, input bit txr);
        bit rx_e, tx_e;
        int head;
        @(negedge clk);
        rx_e    = rxv && (q.size() < ELS);
        tx_e    = txv && (q.size() < ELS);
        m_cmd_v = rx_e || tx_e;
        m_g     = (rx_e && tx_e) ? (last_g == 1 ? 0 : 1) : (tx_e ? 1 : 0);
        m_push  = m_cmd_v && yreq;
        head    = (q.size() > 0) ? q[0] : -1;
        rx_cmd_v_i = rxv;  tx_cmd_v_i = txv;
        rx_cmd_i = rnd_msg(); tx_cmd_i = rnd_msg(); io_resp_i = rnd_msg();
        io_cmd_yumi_i   = m_push;
        io_resp_v_i     = rspv && (q.size() > 0);
        rx_resp_ready_i = rxr;  tx_resp_ready_i = txr;
        m_rdy   = (head == 0 && rxr) || (head == 1 && txr);
        m_rx_rv = io_resp_v_i && head == 0;
        m_tx_rv = io_resp_v_i && head == 1;
        m_pop   = io_resp_v_i && m_rdy;
        #1;
        chki("cmd_v", int'(io_cmd_v_o), int'(m_cmd_v));
        if (m_cmd_v) chkw("cmd_data", io_cmd_o, (m_g == 1) ? tx_cmd_i : rx_cmd_i);
        chki("rx_yumi", int'(rx_cmd_yumi_o), int'(m_push && m_g == 0));
        chki("tx_yumi", int'(tx_cmd_yumi_o), int'(m_push && m_g == 1));
        chki("rx_resp_v", int'(rx_resp_v_o), int'(m_rx_rv));
        chki("tx_resp_v", int'(tx_resp_v_o), int'(m_tx_rv));
        chki("resp_ready", int'(io_resp_ready_o), int'(m_rdy));
        chki("outstanding", int'(outstanding_o), q.size());
        chkw("resp_data", tx_resp_o, io_resp_i);
    endtask

    task automatic adv();
        @(posedge clk);
        if (m_pop)  void'(q.pop_front());
        if (m_push) begin q.push_back(m_g); last_g = m_g; end
    endtask

    task automatic cyc(input bit rxv, input bit txv, input bit yreq,
                       input bit rspv, input bit rxr, input bit txr);
        step(rxv, txv, yreq, rspv, rxr, txr);
        adv();
    endtask

    task automatic clear_inputs();
        rx_cmd_v_i = 0; tx_cmd_v_i = 0; io_cmd_yumi_i = 0; io_resp_v_i = 0;
        rx_resp_ready_i = 0; tx_resp_ready_i = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rx_cmd_v_i = 1; tx_cmd_v_i = 1;
        reset_i = 1;
        #1;
        chki("rst_out", int'(outstanding_o), 0);
        chki("rst_cmd_v", int'(io_cmd_v_o), 0);
        @(negedge clk);
        clear_inputs();
        reset_i = 0;
        q.delete();
        last_g = 1;
    endtask

    typedef struct {
        bit rxv, txv, y, rv, rxr, txr;
        bit e_v, e_g, e_rxy, e_txy, e_rxrv, e_txrv, e_rdy;
        int e_out;
    } vec_t;

    vec_t tbl[19];

    initial begin
        tbl[0]  = '{1,0,1,0,1,1, 1,0,1,0,0,0,0, 0};
        tbl[1]  = '{0,1,1,0,1,1, 1,1,0,1,0,0,1, 1};
        tbl[2]  = '{0,1,1,0,1,1, 1,1,0,1,0,0,1, 2};
        tbl[3]  = '{0,0,0,1,1,1, 0,0,0,0,1,0,1, 3};
        tbl[4]  = '{0,0,0,1,1,1, 0,0,0,0,0,1,1, 2};
        tbl[5]  = '{0,0,0,1,1,1, 0,0,0,0,0,1,1, 1};
        tbl[6]  = '{0,0,0,0,1,1, 0,0,0,0,0,0,0, 0};
        tbl[7]  = '{1,0,1,0,1,1, 1,0,1,0,0,0,0, 0};
        tbl[8]  = '{0,1,1,0,1,1, 1,1,0,1,0,0,1, 1};
        tbl[9]  = '{0,0,0,1,0,1, 0,0,0,0,1,0,0, 2};
        tbl[10] = '{0,0,0,1,0,1, 0,0,0,0,1,0,0, 2};
        tbl[11] = '{0,0,0,1,1,1, 0,0,0,0,1,0,1, 2};
        tbl[12] = '{0,0,0,1,1,1, 0,0,0,0,0,1,1, 1};
        tbl[13] = '{0,0,0,0,1,1, 0,0,0,0,0,0,0, 0};
        tbl[14] = '{1,1,1,0,1,1, 1,0,1,0,0,0,0, 0};
        tbl[15] = '{1,1,1,0,1,1, 1,1,0,1,0,0,1, 1};
        tbl[16] = '{1,1,0,0,1,1, 1,0,0,0,0,0,1, 2};
        tbl[17] = '{1,1,1,0,1,1, 1,0,1,0,0,0,1, 2};
        tbl[18] = '{1,1,1,0,1,1, 1,1,0,1,0,0,1, 3};

        do_reset();
        foreach (tbl[i]) begin
            @(negedge clk);
            rx_cmd_v_i = tbl[i].rxv; tx_cmd_v_i = tbl[i].txv; io_cmd_yumi_i = tbl[i].y;
            io_resp_v_i = tbl[i].rv; rx_resp_ready_i = tbl[i].rxr; tx_resp_ready_i = tbl[i].txr;
            rx_cmd_i = rnd_msg(); tx_cmd_i = rnd_msg(); io_resp_i = rnd_msg();
            #1;
            chki($sformatf("vec%0d_cmd_v", i), int'(io_cmd_v_o), int'(tbl[i].e_v));
            if (tbl[i].e_v)
                chkw($sformatf("vec%0d_cmd", i), io_cmd_o, tbl[i].e_g ? tx_cmd_i : rx_cmd_i);
            chki($sformatf("vec%0d_rx_yumi", i), int'(rx_cmd_yumi_o), int'(tbl[i].e_rxy));
            chki($sformatf("vec%0d_tx_yumi", i), int'(tx_cmd_yumi_o), int'(tbl[i].e_txy));
            chki($sformatf("vec%0d_rx_rv", i), int'(rx_resp_v_o), int'(tbl[i].e_rxrv));
            chki($sformatf("vec%0d_tx_rv", i), int'(tx_resp_v_o), int'(tbl[i].e_txrv));
            chki($sformatf("vec%0d_rdy", i), int'(io_resp_ready_o), int'(tbl[i].e_rdy));
            chki($sformatf("vec%0d_out", i), int'(outstanding_o), tbl[i].e_out);
            chkw($sformatf("vec%0d_rx_resp", i), rx_resp_o, io_resp_i);
        end

        // Alternation up to full, then pop and offer in the same cycle
        do_reset();
        for (int i = 0; i < ELS; i++) begin
            step(1, 1, 1, 0, 1, 1);
            chki("alt_grant_tx", int'(tx_cmd_yumi_o), i % 2);
            adv();
        end
        step(1, 1, 1, 0, 1, 1);
        chki("full_cmd_v", int'(io_cmd_v_o), 0);
        chki("full_out", int'(outstanding_o), ELS);
        adv();
        step(1, 0, 1, 1, 1, 1);
        chki("full_pop_no_yumi", int'(rx_cmd_yumi_o), 0);
        adv();
        step(1, 0, 1, 0, 1, 1);
        chki("after_pop_yumi", int'(rx_cmd_yumi_o), 1);
        adv();
        step(0, 0, 0, 0, 1, 1);
        chki("refill_out", int'(outstanding_o), ELS);
        adv();
        for (int i = 0; i < ELS; i++) cyc(0, 0, 0, 1, 1, 1);

        // Async reset with 4 outstanding
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 1, 1);
        @(negedge clk);
        clear_inputs();
        rx_cmd_v_i = 1; tx_cmd_v_i = 1; io_resp_v_i = 1; rx_resp_ready_i = 1; tx_resp_ready_i = 1;
        #2 reset_i = 1;
        #1;
        chki("arst_out", int'(outstanding_o), 0);
        chki("arst_cmd_v", int'(io_cmd_v_o), 0);
        chki("arst_yumi", int'(rx_cmd_yumi_o | tx_cmd_yumi_o), 0);
        chki("arst_resp_v", int'(rx_resp_v_o | tx_resp_v_o), 0);
        chki("arst_ready", int'(io_resp_ready_o), 0);
        @(negedge clk);
        clear_inputs();
        reset_i = 0;
        q.delete();
        last_g = 1;
        step(1, 1, 1, 0, 1, 1);
        chki("arst_first_tie_rx", int'(rx_cmd_yumi_o), 1);
        adv();

        // Single requester then tie
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1, 0, 1, 1);
            chki("single_tx", int'(tx_cmd_yumi_o), 1);
            adv();
        end
        step(1, 1, 1, 0, 1, 1);
        chki("single_then_tie_rx", int'(rx_cmd_yumi_o), 1);
        adv();

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_io_cmd_arbiter.md
# eth_io_cmd_arbiter

Shares the single BedRock IO command channel of the Ethernet adapter between the RX packet writer and the TX packet reader. Command arbitration is round-robin. The block tracks the requester of every issued command in an order-preserving tag FIFO and routes each returning `io_resp` to the requester that issued it. It sits between the two Ethernet datapath engines and the core's IO interface.

## Interface
- `bp_params_p`, default `e_bp_default_cfg`: processor config; supplies `cce_mem_msg_width_lp`.
- `els_p`, default 8: maximum outstanding commands (tag FIFO depth, ≥2).

- `clk_i` in 1: single clock.
- `reset_i` in 1: reset, asynchronous, active-high.
- `rx_cmd_i` in `cce_mem_msg_width_lp`: RX engine command.
- `rx_cmd_v_i` in 1: RX command valid.
- `rx_cmd_yumi_o` out 1: RX command consumed this cycle.
- `tx_cmd_i` in `cce_mem_msg_width_lp`: TX engine command.
- `tx_cmd_v_i` in 1: TX command valid.
- `tx_cmd_yumi_o` out 1: TX command consumed.
- `rx_resp_o` out `cce_mem_msg_width_lp`: response to RX.
- `rx_resp_v_o` out 1: RX response valid.
- `rx_resp_ready_i` in 1: RX can accept a response.
- `tx_resp_o` out `cce_mem_msg_width_lp`: response to TX.
- `tx_resp_v_o` out 1: TX response valid.
- `tx_resp_ready_i` in 1: TX can accept a response.
- `io_cmd_o` out `cce_mem_msg_width_lp`: granted command.
- `io_cmd_v_o` out 1: command valid.
- `io_cmd_yumi_i` in 1: downstream consumed the command.
- `io_resp_i` in `cce_mem_msg_width_lp`: returning response.
- `io_resp_v_i` in 1: response valid.
- `io_resp_ready_o` out 1: arbiter can route the response.
- `outstanding_o` out `$clog2(els_p+1)`: commands in flight.

## Operation
- **Eligibility**
  - A requester is eligible when its `v_i` is high and the tag FIFO is not full.
  - `io_cmd_v_o` = any eligible requester.
- **Grant selection**
  - Grant is combinational from `last_grant_r`.
  - Both requesters eligible: the one that is not `last_grant_r` wins.
  - One requester eligible: it wins.
  - `io_cmd_o` = the granted requester's message, passed through unmodified.
- **Command handshake**
  - On `io_cmd_yumi_i`, assert the granted requester's `cmd_yumi_o` in the same cycle.
  - In that cycle, push the requester ID (0 = RX, 1 = TX) into the tag FIFO and set `last_grant_r` to that ID.
  - Without yumi, `last_grant_r` is held. The grant may change as the inputs change.
- **Response routing**
  - Head ID selects the destination. `<head>_resp_v_o` = `io_resp_v_i` & FIFO not empty. The other `resp_v_o` is 0.
  - Both `resp_o` ports carry `io_resp_i` unmodified.
  - `io_resp_ready_o` = FIFO not empty & the head requester's `resp_ready_i`.
  - Pop on `io_resp_v_i & io_resp_ready_o`.
- **Counter**
  - `outstanding_o` is the FIFO occupancy.
  - +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.

## Timing
- Command path is zero latency (combinational); response path is zero latency.
- Reset values:
  - `last_grant_r` = TX, so RX wins the first tie.
  - FIFO empty; `outstanding_o` = 0.
  - While `reset_i` is high, all `v_o`, `yumi_o` and `io_resp_ready_o` are forced to 0.
- **Full FIFO** (`outstanding_o == els_p`):
  - `io_cmd_v_o` = 0 and no yumi is issued.
  - No same-cycle pop-to-push bypass; issue resumes the cycle after a pop.
- **Empty FIFO:** `io_resp_ready_o` = 0. `io_resp_v_i` while empty is a protocol error; flag it with a simulation assertion.
- **Push and pop in the same cycle:** both occur; pointers wrap modulo `els_p`.
- **Downstream yumi while `io_cmd_v_o` = 0** is illegal; assert on it.
- **Reset mid-operation:** FIFO and pointer clear immediately (asynchronously). In-flight responses arriving after reset are not routed.
- **Starvation bound:** with both requesters continuously valid and no full-FIFO stall, grants strictly alternate.

## Structure
- Requester ID enum `eth_io_req_e` (`e_eth_io_req_rx` = 0, `e_eth_io_req_tx` = 1) goes in the shared Ethernet package, alongside the RX/TX command enums.
- Tag FIFO is sub-module `eth_io_tag_fifo`:
  - 1-bit data, depth `els_p`, asynchronous active-high reset.
  - Provides full, empty and count.
  - No valid-in/ready-out bypass.
- Arbitration and muxing stay in the top level.

## Test plan
- **Alternation.** RX and TX valid every cycle, yumi every cycle. Expect grants RX, TX, RX, TX. `outstanding_o` climbs to 8 and `io_cmd_v_o` drops to 0 at 8.
- **Response routing.** Issue RX, TX, TX. Return 3 responses. Expect `rx_resp_v_o`, `tx_resp_v_o`, `tx_resp_v_o` in that order, then `outstanding_o` = 0.
- **Head backpressure.** Head = RX with `rx_resp_ready_i` = 0. Expect `io_resp_ready_o` = 0 and no pop until ready rises. A TX response behind it stays queued.
- **Full plus simultaneous events.** At 8 outstanding, pop and offer a command in the same cycle. Expect no yumi that cycle, yumi the next cycle, and the count returns to 8.
- **Single requester.** Only TX valid for 5 cycles after reset. Expect 5 TX grants. Then RX and TX become valid together: RX wins.
- **Async reset.** Assert `reset_i` mid-burst between clock edges with 4 outstanding. Expect immediate `outstanding_o` = 0 and all valids low. After release, the first tie goes to RX.
